// File: rtl/uart_rx_in.sv
// UART 8N1 receiver: synchronizes rx_i, frames bytes LSB first and hands them
// to the core over a valid/ready holding register with framing/overrun flags.
module uart_rx_in #(
  parameter int DIV         = 104,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       ovr_clr_i,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
    $error("uart_rx_in: DIV must be >= 4 and even");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_in: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && ready_i) valid_d = 1'b0;
    if (ovr_clr_i)          ovr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
            // A byte may load on the same edge the previous one is consumed.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_in.sv
// Bench for uart_rx_in: frame-level model (stop-sample time, busy windows,
// holding-register rules) compared every cycle, plus directed literal checks.
module tb_uart_rx_in;

  localparam int DIV  = 8;
  localparam int SYNC = 2;
  // Edges from the first edge that sees the start bit on rx_i to the stop-bit sample.
  localparam int LAT  = SYNC + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx_in #(.DIV(DIV), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .ovr_clr_i  (ovr_clr),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {int at; logic [7:0] d; bit ok;} ev_t;
  typedef struct {int lo; int hi;} win_t;

  ev_t  ev_q[$];
  win_t win_q[$];
  int   ev_rd = 0, win_base = 0;
  int   cyc = 0, checks = 0, errors = 0, dc_ferr = 0;
  bit   dc = 1'b0;
  logic [7:0] m_data = 8'h00, n_data;
  logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
  logic n_valid, n_ferr, n_ovr;
  int   k, e1, e2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; low_stop>0 holds the stop bit low for that many bit periods.
  task automatic send(input logic [7:0] d, input int low_stop);
    int ks;
    ks = cyc + 1;
    ev_q.push_back('{ks + LAT, d, (low_stop == 0)});
    win_q.push_back('{ks + SYNC, (low_stop == 0) ? ks + LAT : ks + (9 + low_stop) * DIV + SYNC});
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    if (low_stop > 0) begin
      rx = 1'b0;
      repeat (low_stop * DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : model_and_compare
        forever begin
          @(posedge clk);
          cyc++;
          if (rst) begin
            m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            ev_rd = ev_q.size();
            win_base = win_q.size();
          end else begin
            n_valid = m_valid; n_data = m_data; n_ovr = m_ovr; n_ferr = 1'b0;
            if (m_valid && ready) n_valid = 1'b0;
            if (ovr_clr) n_ovr = 1'b0;
            if (ev_rd < ev_q.size() && ev_q[ev_rd].at == cyc) begin
              if (ev_q[ev_rd].ok) begin
                if (!m_valid || ready) begin
                  n_data = ev_q[ev_rd].d;
                  n_valid = 1'b1;
                end else begin
                  n_ovr = 1'b1;
                end
              end else begin
                n_ferr = 1'b1;
              end
              ev_rd++;
            end
            m_valid = n_valid; m_data = n_data; m_ovr = n_ovr; m_ferr = n_ferr;
          end
          m_busy = 1'b0;
          for (int i = win_base; i < win_q.size(); i++)
            if (win_q[i].lo <= cyc && cyc < win_q[i].hi) m_busy = 1'b1;
          #1;
          chk("valid", valid_o, m_valid);
          chk("data", data_o, m_data);
          chk("overrun", overrun_o, m_ovr);
          if (dc) begin
            if (frame_err_o) dc_ferr++;
          end else begin
            chk("frame_err", frame_err_o, m_ferr);
            chk("busy", busy_o, m_busy);
          end
        end
      end
      begin : stimulus
        repeat (3) @(negedge clk);
        chk("rst_data", data_o, 8'h00);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ferr", frame_err_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        idle(4);

        // single byte, consumer always ready
        ready = 1'b1;
        e1 = cyc + 1 + LAT;
        fork
          send(8'hA5, 0);
          begin
            wait_cyc(e1);
            chk("t1_data", data_o, 8'hA5);
            chk("t1_valid", valid_o, 1'b1);
            chk("t1_ferr", frame_err_o, 1'b0);
            chk("t1_ovr", overrun_o, 1'b0);
            wait_cyc(e1 + 1);
            chk("t1_valid_drop", valid_o, 1'b0);
          end
        join
        idle(4);

        // overrun while holding register is full
        ready = 1'b0;
        send(8'h3C, 0);
        chk("t2_hold_data", data_o, 8'h3C);
        chk("t2_hold_valid", valid_o, 1'b1);
        chk("t2_no_ovr", overrun_o, 1'b0);
        send(8'h81, 0);
        chk("t2_ovr_set", overrun_o, 1'b1);
        chk("t2_keep_data", data_o, 8'h3C);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("t2_ovr_clr", overrun_o, 1'b0);
        ovr_clr = 1'b1;
        e1 = cyc + 1 + LAT;
        fork
          send(8'h99, 0);
          begin
            wait_cyc(e1);
            chk("t2_set_wins", overrun_o, 1'b1);
          end
        join
        ovr_clr = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("t2_consumed", valid_o, 1'b0);
        chk("t2_final_data", data_o, 8'h3C);
        idle(4);

        // framing error, then recovery
        ready = 1'b1;
        e1 = cyc + 1 + LAT;
        fork
          send(8'h55, 2);
          begin
            wait_cyc(e1);
            chk("t3_ferr", frame_err_o, 1'b1);
            chk("t3_no_valid", valid_o, 1'b0);
            wait_cyc(e1 + 1);
            chk("t3_ferr_once", frame_err_o, 1'b0);
          end
        join
        idle(4);
        e1 = cyc + 1 + LAT;
        fork
          send(8'h0F, 0);
          begin
            wait_cyc(e1);
            chk("t3_next_data", data_o, 8'h0F);
            chk("t3_next_valid", valid_o, 1'b1);
          end
        join
        idle(4);

        // short low glitch: false start
        k = cyc + 1;
        win_q.push_back('{k + SYNC, k + SYNC + DIV / 2});
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        wait_cyc(k + 3);
        chk("t4_busy", busy_o, 1'b1);
        wait_cyc(k + 8);
        chk("t4_idle", busy_o, 1'b0);
        chk("t4_no_valid", valid_o, 1'b0);
        chk("t4_no_ferr", frame_err_o, 1'b0);
        idle(4);

        // back-to-back frames, second one loads on the consuming edge
        ready = 1'b0;
        e1 = cyc + 1 + LAT;
        e2 = e1 + 10 * DIV;
        fork
          begin
            send(8'h00, 0);
            send(8'hFF, 0);
          end
          begin
            wait_cyc(e1);
            chk("t5_first_data", data_o, 8'h00);
            chk("t5_first_valid", valid_o, 1'b1);
            wait_cyc(e2 - 1);
            ready = 1'b1;
            wait_cyc(e2);
            ready = 1'b0;
            chk("t5_second_data", data_o, 8'hFF);
            chk("t5_second_valid", valid_o, 1'b1);
            chk("t5_no_ovr", overrun_o, 1'b0);
          end
        join
        ready = 1'b1;
        @(negedge clk);
        chk("t5_consumed", valid_o, 1'b0);
        idle(4);

        // reset in the middle of data bit 4
        k = cyc + 1;
        fork
          send(8'hC3, 0);
          begin
            wait_cyc(k + 5 * DIV + 3);
            rst = 1'b1;
            dc = 1'b1;
            #1;
            chk("t6_rst_data", data_o, 8'h00);
            chk("t6_rst_valid", valid_o, 1'b0);
            chk("t6_rst_ferr", frame_err_o, 1'b0);
            chk("t6_rst_ovr", overrun_o, 1'b0);
            chk("t6_rst_busy", busy_o, 1'b0);
            wait_cyc(k + 6 * DIV + 5);
            rst = 1'b0;
          end
        join
        idle(20);
        dc = 1'b0;
        chk("t6_ferr_pulses_le1", int'(dc_ferr <= 1), 1);
        e1 = cyc + 1 + LAT;
        fork
          send(8'h7E, 0);
          begin
            wait_cyc(e1);
            chk("t6_data", data_o, 8'h7E);
            chk("t6_valid", valid_o, 1'b1);
          end
        join
        idle(4);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_in.md
Name: uart_rx_in

Overview:
- UART 8N1 receiver sitting directly behind the tt_um_chisel dedicated input pins. The top level routes ui_in[0] to rx_i.
- Converts the serial line into bytes and hands each byte to the core over a valid/ready port.
- Reports framing errors and overruns so the core can flag link problems on uo_out.

Parameters:
- DIV, 104, clock cycles per bit period. Must be ≥4 and even.
- SYNC_STAGES, 2, number of synchronizer flops on rx_i. Must be ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_i  input  1  raw serial line; idles high; asynchronous to clk.
- data_o  output  8  received byte; stable while valid_o=1.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o when valid_o&&ready_i at a rising edge.
- frame_err_o  output  1  one-cycle pulse when the stop bit samples low.
- overrun_o  output  1  sticky: a byte was dropped because the holding register was full.
- ovr_clr_i  input  1  synchronous clear of overrun_o.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, immediate):
  - Synchronizer flops = 1.
  - FSM = IDLE; bit counter and divider counter = 0.
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
- Synchronizer: rx_i passes through SYNC_STAGES flops. rxs denotes the last stage. The FSM sees only rxs.
- Divider counter: counts 0..DIV-1. It is reloaded to 0 on every state entry.
- IDLE:
  - Wait for rxs=0.
  - On rxs=0, go to START with counter 0.
- START:
  - At count DIV/2-1 (mid start bit), sample rxs.
  - If rxs=1: false start, return to IDLE, no outputs change.
  - If rxs=0: go to DATA with bit index 0.
- DATA:
  - Sample rxs each time the counter reaches DIV-1, i.e. mid-bit.
  - Shift the sample into shift[bit], LSB first.
  - After bit 7, go to STOP.
- STOP:
  - At count DIV-1, sample rxs.
  - rxs=1, valid frame:
    - If valid_o=0, or valid_o=1 with ready_i=1 in the same cycle: load data_o←shift, valid_o←1.
    - Otherwise (valid_o=1, ready_i=0): keep the old data_o and set overrun_o←1.
    - In both cases go to IDLE.
  - rxs=0, framing error:
    - Pulse frame_err_o for exactly 1 cycle and discard shift.
    - Go to WAIT_HI.
- WAIT_HI: stay until rxs=1 (break or line-low tolerance), then go to IDLE. No bytes are produced while here.
- Latency: valid_o rises on the edge after the stop-bit sample. That is ≈ SYNC_STAGES + DIV/2 + 9·DIV cycles after the start-bit falling edge on rx_i.
- Handshake:
  - valid_o&&ready_i clears valid_o on the next edge, unless a new byte loads on that same edge, in which case valid_o stays 1 with the new data.
  - valid_o never drops without a handshake.
  - data_o changes only on a load.
- Overrun clear:
  - ovr_clr_i=1 clears overrun_o on the next edge.
  - If a new overrun occurs in the same cycle as the clear, the set wins.
- Back-to-back frames: a start bit immediately following the stop sample is detected, because IDLE is entered right after the stop sample.
- busy_o = (state≠IDLE).
- Reset mid-frame: everything aborts immediately. After release, the FSM waits in IDLE for the next falling edge. A remaining low data bit may be taken as a false start and rejected, or trigger a frame error. Either is acceptable.

Test Plan:
- Reset, then send 0xA5 with DIV=8, ready_i=1:
  - data_o=0xA5 with valid_o=1 for 1 cycle.
  - frame_err_o=0, overrun_o=0.
- ready_i=0, send 0x3C then 0x81:
  - valid_o stays 1 with data_o=0x3C; overrun_o=1 after the second stop bit.
  - ovr_clr_i pulse → overrun_o=0.
  - ready_i=1 → valid_o=0.
- Send 0x55 with the stop bit forced low for 2 bit periods:
  - frame_err_o pulses once; valid_o stays 0.
  - Next frame 0x0F is received correctly.
- Low glitch on rx_i of DIV/4 cycles:
  - busy_o high briefly, then IDLE; no valid_o, no frame_err_o.
- Send 0x00 then 0xFF back-to-back (no idle gap), consuming each byte:
  - Both bytes are received in order.
  - Assert ready_i on the exact cycle the second byte loads: valid_o stays 1, data_o=0xFF, overrun_o=0.
- Assert rst during data bit 4 of 0xC3, release, then send 0x7E:
  - All outputs reset immediately.
  - Only 0x7E is delivered, possibly preceded by a single frame_err_o pulse.
